bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader_if.sv | 31 +++
 rtl/bram_stream_reader.sv | 135 +++++++++++++
 tb/tb_bram_stream_reader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Control, BRAM-port and stream signals of the BRAM burst reader; master is the reader side.
interface bram_stream_reader_if #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 48
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);

  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [ADDR_W:0]      len;
  logic                 busy;
  logic                 done;
  logic [ADDR_W-1:0]    bram_addr;
  logic                 bram_en;
  logic                 bram_we;
  logic                 bram_flush;
  logic [RAM_WIDTH-1:0] bram_dout;
  logic [RAM_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    input  start, base_addr, len, bram_dout, m_ready,
    output busy, done, bram_addr, bram_en, bram_we, bram_flush, m_data, m_valid
  );

  modport slave (
    output start, base_addr, len, bram_dout, m_ready,
    input  busy, done, bram_addr, bram_en, bram_we, bram_flush, m_data, m_valid
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams len words from a 1-cycle-latency BRAM through a 2-entry FIFO; first m_valid 2 cycles after start.
// Define BRAM_STREAM_READER_FLUSH_EN to add a one-cycle FLUSH state that pulses bram_flush after each burst.
module bram_stream_reader #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 48
) (
  input  logic                 clka,
  input  logic                 resetn,
  bram_stream_reader_if.master bus
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);

`ifdef BRAM_STREAM_READER_FLUSH_EN
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif

  state_t               state_q;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [ADDR_W-1:0]    last_addr_q;
  logic [ADDR_W:0]      rd_left_q;
  logic                 rd_vld_q;
  logic [1:0]           cnt_q;
  logic [RAM_WIDTH-1:0] head_q;
  logic [RAM_WIDTH-1:0] tail_q;
  logic                 done_q;
`ifdef BRAM_STREAM_READER_FLUSH_EN
  logic                 flush_q;
`endif

  logic              pop;
  logic              issue;
  logic              drain_exit;
  logic [ADDR_W-1:0] nxt_addr;

  // Issue looks at this cycle's pop so a full-rate stream keeps one word queued and one in flight.
  assign pop        = (cnt_q != 2'd0) && bus.m_ready;
  assign issue      = (state_q == READ) &&
                      (({1'b0, cnt_q} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop}));
  assign drain_exit = (state_q == DRAIN) && !rd_vld_q &&
                      ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));
  assign nxt_addr   = (rd_addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : rd_addr_q + 1'b1;

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.bram_en   = issue;
  assign bus.bram_addr = issue ? rd_addr_q : last_addr_q;
  assign bus.bram_we   = 1'b0;
  assign bus.m_valid   = (cnt_q != 2'd0);
  assign bus.m_data    = head_q;
`ifdef BRAM_STREAM_READER_FLUSH_EN
  assign bus.bram_flush = flush_q;
`else
  assign bus.bram_flush = 1'b0;
`endif

  always_ff @(posedge clka) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
      rd_left_q   <= '0;
      rd_vld_q    <= 1'b0;
      cnt_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      done_q      <= 1'b0;
`ifdef BRAM_STREAM_READER_FLUSH_EN
      flush_q     <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
`ifdef BRAM_STREAM_READER_FLUSH_EN
      flush_q  <= 1'b0;
`endif
      rd_vld_q <= issue;

      // bram_dout is only looked at in the cycle after a read was issued
      if (rd_vld_q && pop) begin
        if (cnt_q == 2'd1) begin
          head_q <= bus.bram_dout;
        end else begin
          head_q <= tail_q;
          tail_q <= bus.bram_dout;
        end
      end else if (rd_vld_q) begin
        if (cnt_q == 2'd0) head_q <= bus.bram_dout;
        else               tail_q <= bus.bram_dout;
        cnt_q <= cnt_q + 2'd1;
      end else if (pop) begin
        head_q <= tail_q;
        cnt_q  <= cnt_q - 2'd1;
      end

      if (issue) begin
        last_addr_q <= rd_addr_q;
        rd_addr_q   <= nxt_addr;
        rd_left_q   <= rd_left_q - 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len == '0) begin
              done_q <= 1'b1;
            end else begin
              rd_addr_q <= bus.base_addr;
              rd_left_q <= bus.len;
              state_q   <= READ;
            end
          end
        end
        READ: begin
          if (issue && (rd_left_q == {{ADDR_W{1'b0}}, 1'b1})) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drain_exit) begin
            done_q  <= 1'b1;
`ifdef BRAM_STREAM_READER_FLUSH_EN
            flush_q <= 1'b1;
            state_q <= FLUSH;
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef BRAM_STREAM_READER_FLUSH_EN
        FLUSH: state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a BRAM model preloaded with mem[i]=i.
module tb_bram_stream_reader;
  logic clka = 1'b0;
  logic resetn;
  logic flushed_m = 1'b0;
  bit   exp_flushed = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fv, lx, dc;

  always #5 clka = ~clka;

  bram_stream_reader_if #(.RAM_WIDTH(8), .RAM_DEPTH(48)) bus ();

  bram_stream_reader #(.RAM_WIDTH(8), .RAM_DEPTH(48)) dut (
    .clka   (clka),
    .resetn (resetn),
    .bus    (bus)
  );

  // mem[i] = i until a flush clears every word
  always @(posedge clka) begin
    if (bus.bram_flush) flushed_m <= 1'b1;
    if (bus.bram_en) bus.bram_dout <= flushed_m ? 8'd0 : {2'b00, bus.bram_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return exp_flushed ? 32'd0 : 32'(k % 48);
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_done"},    bus.done, 0);
    check({tag, "_en"},      bus.bram_en, 0);
    check({tag, "_addr"},    bus.bram_addr, 0);
    check({tag, "_we"},      bus.bram_we, 0);
    check({tag, "_flush"},   bus.bram_flush, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_data"},  bus.m_data, 0);
  endtask

  // Called at a negedge; c=0 is the cycle after the edge that accepts start.
  task automatic run_burst(input int base, input int n, input bit toggle, input int poke_cyc,
                           output int first_vld, output int last_xfer, output int done_cyc);
    int          issued;
    int          xfer;
    bit          stalled;
    logic [7:0]  held;
    issued = 0; xfer = 0; stalled = 1'b0; held = '0;
    first_vld = -1; last_xfer = -1; done_cyc = -1;
    bus.start = 1'b1; bus.base_addr = 6'(base); bus.len = 7'(n); bus.m_ready = 1'b1;
    @(negedge clka);
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      if (c == poke_cyc) begin
        bus.start = 1'b1; bus.base_addr = 6'd30; bus.len = 7'd3;
      end else begin
        bus.start = 1'b0;
      end
      bus.m_ready = toggle ? (c % 3 == 0) : 1'b1;
      #1;
      if (stalled) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_data", bus.m_data, held);
      end
      if (bus.bram_en) begin
        check("rd_addr", bus.bram_addr, 32'((base + issued) % 48));
        issued++;
      end
      check("outstanding_le2", 32'((issued - xfer - int'(bus.m_valid && bus.m_ready)) <= 2), 1);
      if (bus.m_valid && bus.m_ready) begin
        check("data", bus.m_data, exp_word(base + xfer));
        xfer++;
        last_xfer = c;
      end
      if (bus.m_valid && first_vld < 0) first_vld = c;
      stalled = bus.m_valid && !bus.m_ready;
      held    = bus.m_data;
      check("we_zero", bus.bram_we, 0);
      if (bus.done) begin
        done_cyc = c;
`ifdef BRAM_STREAM_READER_FLUSH_EN
        check("done_busy", bus.busy, 1);
        check("flush_with_done", bus.bram_flush, 1);
`else
        check("done_busy", bus.busy, 0);
`endif
      end else begin
        check("flush_low", bus.bram_flush, 0);
      end
      @(negedge clka);
    end
    bus.start = 1'b0;
    check("done_seen", 32'(done_cyc >= 0), 1);
    check("xfer_count", xfer, n);
    check("issue_count", issued, n);
    check("done_after_last", done_cyc, last_xfer + 1);
    check("done_one_cycle", bus.done, 0);
    check("post_busy", bus.busy, 0);
    check("post_flush", bus.bram_flush, 0);
`ifdef BRAM_STREAM_READER_FLUSH_EN
    if (n > 0) exp_flushed = 1'b1;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clka);
    chk_idle("reset");
    resetn = 1'b1;
    @(negedge clka);

    // base 0, len 4, full rate
    run_burst(0, 4, 1'b0, -1, fv, lx, dc);
    check("b0_first_valid", fv, 2);
    check("b0_last_xfer", lx, 5);
    check("b0_done", dc, 6);

    // address wrap 46,47,0,1
    run_burst(46, 4, 1'b0, -1, fv, lx, dc);
    check("wrap_first_valid", fv, 2);
    check("wrap_done", dc, 6);

    // backpressure 1,0,0 pattern
    run_burst(10, 8, 1'b1, -1, fv, lx, dc);

    // len = 0: no reads, done next cycle
    bus.start = 1'b1; bus.base_addr = 6'd7; bus.len = 7'd0; bus.m_ready = 1'b1;
    @(negedge clka);
    bus.start = 1'b0;
    check("len0_done", bus.done, 1);
    check("len0_busy", bus.busy, 0);
    check("len0_en", bus.bram_en, 0);
    check("len0_flush", bus.bram_flush, 0);
    @(negedge clka);
    check("len0_done_low", bus.done, 0);
    check("len0_en_later", bus.bram_en, 0);

    // start while busy is ignored
    run_burst(20, 5, 1'b0, 2, fv, lx, dc);
    check("poke_done", dc, 7);

    // reset in the middle of a len=10 burst
    bus.start = 1'b1; bus.base_addr = 6'd5; bus.len = 7'd10; bus.m_ready = 1'b1;
    @(negedge clka);
    bus.start = 1'b0;
    repeat (3) @(negedge clka);
    check("mid_busy", bus.busy, 1);
    check("mid_valid", bus.m_valid, 1);
    check("mid_data", bus.m_data, exp_word(6));
    resetn = 1'b0;
    @(negedge clka);
    chk_idle("rst_mid");
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clka);
      check("rst_no_done", bus.done, 0);
      check("rst_idle_busy", bus.busy, 0);
    end

    // new burst after the abort
    run_burst(0, 3, 1'b0, -1, fv, lx, dc);
    check("after_rst_first_valid", fv, 2);
    check("after_rst_done", dc, 5);

    // short bursts around the flush point
    run_burst(0, 2, 1'b0, -1, fv, lx, dc);
    check("len2_done", dc, 4);
    run_burst(3, 2, 1'b0, -1, fv, lx, dc);
    check("len2b_done", dc, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
